// File: rtl/ethernet_crc_pkg.sv
// Shared CRC-32 (IEEE 802.3) constants and byte-wide next-state helpers for the
// Ethernet FCS generator and RX checker.
package ethernet_crc_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    // Per-cycle register operation, decoded from init/d_valid/calc
    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_INIT  = 2'd1,
        OP_CALC  = 2'd2,
        OP_SHIFT = 2'd3
    } crc_op_e;

    // Folds one byte into an MSB-first register; d[0] is first on the wire.
    function automatic logic [31:0] crc32_next_d8(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int unsigned k = 0; k < 8; k++) begin
            fb = r[31] ^ d[k];
            r  = {r[30:0], 1'b0} ^ (fb ? CRC32_POLY : '0);
        end
        return r;
    endfunction

    // Top register byte to wire-order FCS byte: bit-reversed and inverted.
    function automatic logic [7:0] fcs_byte(input logic [7:0] x);
        logic [7:0] o;
        for (int unsigned i = 0; i < 8; i++) begin
            o[i] = ~x[7 - i];
        end
        return o;
    endfunction

endpackage

// File: rtl/ethernet_crc_8_gen_if.sv
// Byte-stream and result bundle for the Ethernet CRC generator.
interface ethernet_crc_8_gen_if;

    logic [7:0]  d;
    logic        calc;
    logic        init;
    logic        d_valid;
    logic [31:0] crc_reg;
    logic [7:0]  crc;

    modport master (
        output d, calc, init, d_valid,
        input  crc_reg, crc
    );

    modport slave (
        input  d, calc, init, d_valid,
        output crc_reg, crc
    );

endinterface

// File: rtl/ethernet_crc_8_gen_next.sv
// Combinational one-byte CRC-32 step, shared by the TX generator and RX checker.
module crc32_d8_next
    import ethernet_crc_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_d,
    output logic [31:0] o_crc
);

    assign o_crc = crc32_next_d8(i_crc, i_d);

endmodule

// File: rtl/ethernet_crc_8_gen.sv
// Byte-serial Ethernet FCS generator/checker: folds data while calc=1, then
// shifts the FCS out in wire order while calc=0.
module ethernet_crc_8_gen
    import ethernet_crc_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    ethernet_crc_8_gen_if.slave bus
);

    logic [31:0] r_crc_reg;
    logic [7:0]  r_crc;
    logic [31:0] w_next;
    crc_op_e     w_op;

    crc32_d8_next u_next (
        .i_crc (r_crc_reg),
        .i_d   (bus.d),
        .o_crc (w_next)
    );

    always_comb begin
        w_op = OP_HOLD;
        if (bus.init) begin
            w_op = OP_INIT;
        end else if (bus.d_valid) begin
            w_op = bus.calc ? OP_CALC : OP_SHIFT;
        end
    end

    // The shift path refills with ones so a fourth shift restores the init value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_crc_reg <= CRC32_INIT;
            r_crc     <= '0;
        end else begin
            case (w_op)
                OP_INIT: begin
                    r_crc_reg <= CRC32_INIT;
                    r_crc     <= '0;
                end
                OP_CALC: begin
                    r_crc_reg <= w_next;
                    r_crc     <= fcs_byte(w_next[31:24]);
                end
                OP_SHIFT: begin
                    r_crc_reg <= {r_crc_reg[23:0], 8'hFF};
                    r_crc     <= fcs_byte(r_crc_reg[23:16]);
                end
                default: begin
                    r_crc_reg <= r_crc_reg;
                    r_crc     <= r_crc;
                end
            endcase
        end
    end

    assign bus.crc_reg = r_crc_reg;
    assign bus.crc     = r_crc;

endmodule

// File: tb/tb_ethernet_crc_8_gen.sv
// Directed self-checking bench for ethernet_crc_8_gen.
module tb_ethernet_crc_8_gen;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [7:0]  chk_str [0:8];
    logic [7:0]  frame   [0:63];
    logic [31:0] refl_s;

    ethernet_crc_8_gen_if bus ();

    ethernet_crc_8_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reflected (LSB-first, right-shifting) reference CRC step
    function automatic logic [31:0] refl_update(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31 - i];
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.init    = 1'b0;
        bus.d_valid = 1'b0;
        bus.calc    = 1'b0;
        bus.d       = 8'h00;
    endtask

    task automatic do_init();
        bus.init    = 1'b1;
        bus.d_valid = 1'b0;
        cyc();
        bus.init    = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic c);
        bus.d       = b;
        bus.calc    = c;
        bus.d_valid = 1'b1;
        cyc();
        bus.d_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        repeat (10) cyc();
        checks++;
        if (bus.crc_reg !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL reset_crc_reg got=%h exp=%h", bus.crc_reg, 32'hFFFFFFFF);
        end
        checks++;
        if (bus.crc !== 8'h00) begin
            failures++;
            $display("FAIL reset_crc got=%h exp=%h", bus.crc, 8'h00);
        end
        reset = 1'b0;
        bus.d    = 8'hA5;
        bus.calc = 1'b1;
        repeat (3) cyc();
        checks++;
        if (bus.crc_reg !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL hold_crc_reg got=%h exp=%h", bus.crc_reg, 32'hFFFFFFFF);
        end
        checks++;
        if (bus.crc !== 8'h00) begin
            failures++;
            $display("FAIL hold_crc got=%h exp=%h", bus.crc, 8'h00);
        end
    endtask

    task automatic test_check_string(input logic stall);
        logic [7:0] exp_sh [0:2];
        exp_sh[0] = 8'h39; exp_sh[1] = 8'hF4; exp_sh[2] = 8'hCB;
        do_init();
        for (int i = 0; i < 9; i++) begin
            send(chk_str[i], 1'b1);
            if (stall) repeat (i % 3 + 1) cyc();
        end
        checks++;
        if (bus.crc_reg !== 32'h9B63D02C) begin
            failures++;
            $display("FAIL str_crc_reg stall=%0d got=%h exp=%h", stall, bus.crc_reg, 32'h9B63D02C);
        end
        checks++;
        if (bus.crc !== 8'h26) begin
            failures++;
            $display("FAIL str_fcs0 stall=%0d got=%h exp=%h", stall, bus.crc, 8'h26);
        end
        for (int j = 0; j < 3; j++) begin
            send(8'h00, 1'b0);
            if (stall) cyc();
            checks++;
            if (bus.crc !== exp_sh[j]) begin
                failures++;
                $display("FAIL str_fcs%0d stall=%0d got=%h exp=%h", j + 1, stall, bus.crc, exp_sh[j]);
            end
        end
        send(8'h00, 1'b0);
        checks++;
        if (bus.crc_reg !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL str_4th_shift stall=%0d got=%h exp=%h", stall, bus.crc_reg, 32'hFFFFFFFF);
        end
        checks++;
        if (bus.crc !== 8'h00) begin
            failures++;
            $display("FAIL str_4th_crc stall=%0d got=%h exp=%h", stall, bus.crc, 8'h00);
        end
    endtask

    task automatic test_frame();
        do_init();
        for (int i = 0; i < 60; i++) send(frame[i], 1'b1);
        checks++;
        if (bus.crc_reg !== bitrev32(refl_s)) begin
            failures++;
            $display("FAIL frame_crc_reg got=%h exp=%h", bus.crc_reg, bitrev32(refl_s));
        end
        checks++;
        if (bus.crc !== frame[60]) begin
            failures++;
            $display("FAIL frame_fcs0 got=%h exp=%h", bus.crc, frame[60]);
        end
        for (int j = 1; j < 4; j++) begin
            send(8'h00, 1'b0);
            checks++;
            if (bus.crc !== frame[60 + j]) begin
                failures++;
                $display("FAIL frame_fcs%0d got=%h exp=%h", j, bus.crc, frame[60 + j]);
            end
        end
    endtask

    task automatic test_residue();
        do_init();
        for (int i = 0; i < 64; i++) send(frame[i], 1'b1);
        checks++;
        if (bus.crc_reg !== 32'hC704DD7B) begin
            failures++;
            $display("FAIL residue got=%h exp=%h", bus.crc_reg, 32'hC704DD7B);
        end
    endtask

    task automatic test_priority();
        do_init();
        send(8'h31, 1'b1);
        send(8'h32, 1'b1);
        bus.init    = 1'b1;
        bus.d_valid = 1'b1;
        bus.calc    = 1'b1;
        bus.d       = 8'h33;
        cyc();
        idle();
        checks++;
        if (bus.crc_reg !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL prio_init_reg got=%h exp=%h", bus.crc_reg, 32'hFFFFFFFF);
        end
        checks++;
        if (bus.crc !== 8'h00) begin
            failures++;
            $display("FAIL prio_init_crc got=%h exp=%h", bus.crc, 8'h00);
        end
        send(8'h31, 1'b1);
        reset       = 1'b1;
        bus.init    = 1'b1;
        bus.d_valid = 1'b1;
        bus.calc    = 1'b1;
        bus.d       = 8'h34;
        cyc();
        reset = 1'b0;
        idle();
        checks++;
        if (bus.crc_reg !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL prio_reset_reg got=%h exp=%h", bus.crc_reg, 32'hFFFFFFFF);
        end
        checks++;
        if (bus.crc !== 8'h00) begin
            failures++;
            $display("FAIL prio_reset_crc got=%h exp=%h", bus.crc, 8'h00);
        end
    endtask

    initial begin
        logic [31:0] fcs;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        idle();

        for (int i = 0; i < 9; i++) chk_str[i] = 8'h31 + i[7:0];

        // Minimum-size frame: broadcast DA, fixed SA, IPv4 type, patterned payload
        for (int i = 0; i < 6; i++) frame[i] = 8'hFF;
        for (int i = 0; i < 6; i++) frame[6 + i] = 8'h11 * i[7:0];
        frame[12] = 8'h08;
        frame[13] = 8'h00;
        for (int i = 14; i < 60; i++) frame[i] = (i[7:0] * 8'd7) + 8'd3;
        refl_s = 32'hFFFFFFFF;
        for (int i = 0; i < 60; i++) refl_s = refl_update(refl_s, frame[i]);
        fcs = ~refl_s;
        for (int j = 0; j < 4; j++) frame[60 + j] = fcs[8 * j +: 8];

        test_reset();
        test_check_string(1'b0);
        test_frame();
        test_residue();
        test_check_string(1'b1);
        test_priority();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
